// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 2-flop synchroniser, centre sampling, one-cycle valid/frame-error strobes.
// Optional majority-of-three sampling is enabled by defining UART_RX_MAJORITY_EN.
`timescale 1ns/1ps

module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned WORD         = 8
) (
    input  logic            i_Clock,
    input  logic            i_Rst_n,
    input  logic            i_Rx_Serial,
    output logic            o_Rx_DV,
    output logic [WORD-1:0] o_Rx_Byte,
    output logic            o_Rx_Frame_Err,
    output logic            o_Rx_Active
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(WORD + 1);
    localparam int unsigned H     = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD-1:0]   shift_q, shift_d;
    logic [WORD-1:0]   byte_d;
    logic              dv_d, ferr_d, active_d;

    logic              rx_meta, rx_s;
    logic              sample;

    // Line idles high, so both synchroniser flops reset to 1
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Three-sample window: current rx_s plus the two previous edges
    logic [1:0] rx_hist;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_s};
        end
    end

    assign sample = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
    assign sample = rx_s;
`endif

    // State, counters, shift register and registered outputs
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            shift_q        <= '0;
            o_Rx_Byte      <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Active    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shift_q        <= shift_d;
            o_Rx_Byte      <= byte_d;
            o_Rx_DV        <= dv_d;
            o_Rx_Frame_Err <= ferr_d;
            o_Rx_Active    <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = o_Rx_Byte;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        active_d = o_Rx_Active;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!sample) begin
                        state_d = DATA;
                    end else begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // LSB arrives first, so shifting in from the top leaves bit 0 at the bottom
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[WORD-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = CLEANUP;
                    if (sample) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CLEANUP: begin
                cnt_d    = '0;
                active_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

endmodule
